// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and widths for the I2C responder.
// Contents: responder FSM state encoding, address/byte widths.
// No logic; imported by i2c_slave_resp and its sub-modules.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WR_DATA   = 3'd3,
    WR_ACK    = 3'd4,
    RD_DATA   = 3'd5,
    RD_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } i2c_slv_state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: synchronizes one asynchronous bus line and flags its edges.
// Latency: SYNC_STAGES clk_in cycles to level_out; rise/fall flags combinational from it.
// Ports: clk_in, reset_in (async, active-high), line_in -> level_out, rise_out, fall_out.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic line_in,
  output logic level_out,
  output logic rise_out,
  output logic fall_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Reset to 1: an idle I2C bus floats high, so no false edge is seen after reset.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_out = sync_q[SYNC_STAGES-1];
  assign rise_out  = level_out & ~prev_q;
  assign fall_out  = ~level_out & prev_q;

endmodule

// File: rtl/i2c_slave_resp.sv
// i2c_slave_resp: I2C target; decodes START/STOP, 7-bit address and R/W, ACKs writes,
// shifts read bytes out. Bus edge -> FSM reaction is SYNC_STAGES+1 clk_in cycles.
// Ports: clk_in, reset_in (async high), scl_in/sda_in (async bus), sda_oe_out/scl_oe_out
// (1 = pull low), rx_data_out/rx_valid_out/rx_ready_in (write sink),
// tx_data_in/tx_load_out (read source), busy_out.
// Build option: define I2C_SLV_STRETCH_EN to hold SCL low while rx_ready_in=0 after a byte.
module i2c_slave_resp
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe_out,
  output logic                  scl_oe_out,
  output logic [I2C_BYTE_W-1:0] rx_data_out,
  output logic                  rx_valid_out,
  input  logic                  rx_ready_in,
  input  logic [I2C_BYTE_W-1:0] tx_data_in,
  output logic                  tx_load_out,
  output logic                  busy_out
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .line_in   (scl_in),
    .level_out (scl_lvl),
    .rise_out  (scl_rise),
    .fall_out  (scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .line_in   (sda_in),
    .level_out (sda_lvl),
    .rise_out  (sda_rise),
    .fall_out  (sda_fall)
  );

  // SDA only legally moves while SCL is low; a move with SCL high is a bus condition.
  logic start_det, stop_det;
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  i2c_slv_state_e        state_q, state_d;
  logic [I2C_BYTE_W-1:0] shift_q, shift_d;
  logic [I2C_BYTE_W-1:0] tx_shift_q, tx_shift_d;
  logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic                  rw_q, rw_d;
  logic                  sda_oe_q, sda_oe_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_load_q, tx_load_d;
  logic                  busy_q, busy_d;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      tx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      rx_valid_q <= rx_valid_d;
      tx_load_q  <= tx_load_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;
    busy_d     = busy_q;

    // Bus conditions take priority over any SCL edge seen in the same cycle.
    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
        end

        ADDR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[I2C_BYTE_W-2:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (shift_q[I2C_BYTE_W-1:1] == SLAVE_ADDR) begin
              rw_d     = shift_q[0];
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              state_d  = ADDR_ACK;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end

        // Entered on an SCL fall, so the next fall closes a full ACK clock.
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              tx_load_d  = 1'b1;
              tx_shift_d = {tx_data_in[I2C_BYTE_W-2:0], 1'b0};
              sda_oe_d   = ~tx_data_in[I2C_BYTE_W-1];
              bit_cnt_d  = 4'd1;
              state_d    = RD_DATA;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = WR_DATA;
            end
          end
        end

        WR_DATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[I2C_BYTE_W-2:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              rx_data_d  = {shift_q[I2C_BYTE_W-2:0], sda_lvl};
              rx_valid_d = 1'b1;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            state_d  = WR_ACK;
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = WR_DATA;
          end
        end

        // bit_cnt counts bits already placed on SDA; bit7 went out on entry.
        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = RD_ACK;
            end else begin
              sda_oe_d   = ~tx_shift_q[I2C_BYTE_W-1];
              tx_shift_d = {tx_shift_q[I2C_BYTE_W-2:0], 1'b0};
              bit_cnt_d  = bit_cnt_q + 4'd1;
            end
          end
        end

        // A NACK is final on its rising edge; an ACK fetches the next byte on the fall.
        RD_ACK: begin
          if (scl_rise && sda_lvl) begin
            state_d = WAIT_STOP;
          end else if (scl_fall) begin
            tx_load_d  = 1'b1;
            tx_shift_d = {tx_data_in[I2C_BYTE_W-2:0], 1'b0};
            sda_oe_d   = ~tx_data_in[I2C_BYTE_W-1];
            bit_cnt_d  = 4'd1;
            state_d    = RD_DATA;
          end
        end

        WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

`ifdef I2C_SLV_STRETCH_EN
  // A byte delivered to a sink that is not ready arms a stretch; SCL is grabbed on
  // the following fall (the ACK slot) and held until the sink catches up.
  logic stretch_pend_q;
  logic scl_oe_q;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      stretch_pend_q <= 1'b0;
      scl_oe_q       <= 1'b0;
    end else if (rx_ready_in) begin
      stretch_pend_q <= 1'b0;
      scl_oe_q       <= 1'b0;
    end else begin
      if (rx_valid_q) begin
        stretch_pend_q <= 1'b1;
      end
      if (stretch_pend_q && scl_fall) begin
        scl_oe_q <= 1'b1;
      end
    end
  end

  assign scl_oe_out = scl_oe_q;
`else
  logic unused_rx_ready;
  assign unused_rx_ready = rx_ready_in;
  assign scl_oe_out      = 1'b0;
`endif

  assign sda_oe_out   = sda_oe_q;
  assign rx_data_out  = rx_data_q;
  assign rx_valid_out = rx_valid_q;
  assign tx_load_out  = tx_load_q;
  assign busy_out     = busy_q;

endmodule
